// File: rtl/score_disp_pkg.sv
// -----------------------------------------------------------------------------
// score_disp_pkg
// Shared definitions for the score/timer display path: the digit width, the
// code the seven-segment decoder renders as a dark digit, and the state
// encoding of the binary-to-BCD converter FSM.
// -----------------------------------------------------------------------------
package score_disp_pkg;

   localparam int DIGIT_W = 4;

   // Decoder shows this code as an unlit digit.
   localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hA;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// -----------------------------------------------------------------------------
// bcd_adj3
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more, so that the following left shift carries into the next
// digit exactly when the doubled value reaches 10.
// Ports:
//   digit     in   DIGIT_W  current scratch digit (never above 9)
//   adjusted  out  DIGIT_W  digit after the conditional +3
// -----------------------------------------------------------------------------
module bcd_adj3
   import score_disp_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adjusted
);

   // Inputs stay within 0..9, so the 4-bit sum never wraps (max 9+3 = 12).
   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/score_bin2bcd.sv
// -----------------------------------------------------------------------------
// score_bin2bcd
// Sequential binary-to-BCD converter for the score/timer display. A start
// strobe in IDLE latches the operand; the shift-and-add-3 algorithm then runs
// one bit per clock. On completion the digits are saturated to all nines if
// the value did not fit, otherwise optionally leading-zero blanked.
// Ports:
//   clk       in   1           system clock, rising edge
//   reset     in   1           asynchronous, active-low
//   start     in   1           conversion request, sampled only in IDLE
//   value     in   WIDTH       unsigned operand, sampled with start
//   blank_lz  in   1           leading-zero blanking enable, sampled with start
//   busy      out  1           conversion in progress
//   done      out  1           one-cycle pulse when bcd/overflow update
//   overflow  out  1           last result exceeded DIGITS digits
//   bcd       out  4*DIGITS    result digits, digit 0 in [3:0]
// -----------------------------------------------------------------------------
module score_bin2bcd
   import score_disp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WIDTH-1:0]           value,
   input  logic                       blank_lz,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic [DIGITS*DIGIT_W-1:0]  bcd
);

   localparam int BCD_W = DIGITS * DIGIT_W;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [WIDTH-1:0]    bin_sr;
   logic [BCD_W-1:0]    scratch;
   logic [BCD_W-1:0]    adjusted;
   logic [BCD_W-1:0]    scratch_next;
   logic                ovf_scratch;
   logic                ovf_next;
   logic                blank_q;

   // Overflowed results are shown as all nines.
   function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] digits,
                                                  input logic            ovf);
      return ovf ? {DIGITS{4'h9}} : digits;
   endfunction

   // Replace leading zero digits with the blank code; digit 0 is always shown.
   function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] digits);
      logic [BCD_W-1:0] r;
      logic             leading;
      r       = digits;
      leading = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         if (leading && digits[d*DIGIT_W +: DIGIT_W] == 4'h0)
            r[d*DIGIT_W +: DIGIT_W] = BLANK_CODE;
         else
            leading = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] digits,
                                                       input logic            ovf,
                                                       input logic            blank);
      if (ovf)
         return saturate(digits, ovf);
      else if (blank)
         return blank_leading(digits);
      else
         return digits;
   endfunction

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_adj3 u_adj (
         .digit    (scratch[d*DIGIT_W +: DIGIT_W]),
         .adjusted (adjusted[d*DIGIT_W +: DIGIT_W])
      );
   end

   // The bit leaving the top digit can only be set when the value needs one
   // more digit than we have, so it is sticky for the whole conversion.
   assign scratch_next = {adjusted[BCD_W-2:0], bin_sr[WIDTH-1]};
   assign ovf_next     = ovf_scratch | adjusted[BCD_W-1];
   assign busy         = (state == SHIFT);

   // Control and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  cnt   <= CNT_LOAD;
               end
            end
            SHIFT: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state    <= IDLE;
                  done     <= 1'b1;
                  overflow <= ovf_next;
                  bcd      <= format_result(scratch_next, ovf_next, blank_q);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Conversion scratch datapath; only meaningful while state is SHIFT, and
   // fully reloaded on every accepted start.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (start) begin
            bin_sr      <= value;
            scratch     <= '0;
            ovf_scratch <= 1'b0;
            blank_q     <= blank_lz;
         end
      end else begin
         bin_sr      <= {bin_sr[WIDTH-2:0], 1'b0};
         scratch     <= scratch_next;
         ovf_scratch <= ovf_next;
      end
   end

endmodule
